info_uart_rx: RTL
=================

Name: info_uart_rx

Overview:
- UART receive path for operator input: deserialises 8N1 serial data and parses ASCII unsigned decimal tokens separated by whitespace.
- Emits one binary value per token, for example matrix dimensions or element values typed on a host terminal.
- Counterpart of the info transmitter that sends ASCII matrix counts; sits between the board RX pin and the input control FSM.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- MAX_DIGITS, 3, maximum digits accepted per token.
- Derived constant (not a parameter): CLKS_PER_BIT = CLK_FREQ/BAUD (868 at defaults); counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  in  1  system clock.
- uartRxRst  in  1  synchronous active-high reset.
- uartRx  in  1  serial input, idle high, asynchronous to clk.
- rxClear  in  1  synchronous parser clear; discards a partial token. Byte receiver unaffected.
- numData  out  8  value of the last completed token.
- numValid  out  1  one-cycle pulse; numData valid this cycle.
- numCount  out  8  number of tokens emitted since reset or rxClear; wraps 255->0.
- ovfErr  out  1  one-cycle pulse: token value >255 or digit count >MAX_DIGITS.
- charErr  out  1  one-cycle pulse: byte that is neither a digit nor a separator.
- frameErr  out  1  one-cycle pulse: stop bit sampled low.
- rxBusy  out  1  high from start-bit detect until the stop-bit sample.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (uartRx input synchronised to clk, uartRxRst).
- Reset clears all outputs to 0, numData to 0, both FSMs to idle, synchroniser flops to 1.
- Reset mid-frame or mid-token abandons the frame/token with no pulse.
- Input sync: 2-flop synchroniser on uartRx. All sampling uses the synchronised signal.
- Byte FSM:
  - IDLE -> START on synchronised uartRx == 0.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 1, this is a false start: return to IDLE with no error. If 0, go to DATA.
  - DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first, shifted into the byte register.
  - STOP: sample after CLKS_PER_BIT. If 1, pulse internal byteValid for 1 cycle. If 0, pulse frameErr, discard the byte, and go to IDLE. Return to IDLE immediately in both cases.
  - No break/idle-line handling beyond this.
- Parser FSM, advanced only on byteValid:
  - SEP: a digit 0x30-0x39 gives acc = d, nd = 1, go to NUM. A separator (0x20, 0x0D, 0x0A) stays in SEP. Any other byte pulses charErr and goes to DISCARD.
  - NUM: a digit gives acc = acc*10 + d, computed in a 12-bit accumulator, nd = nd+1. If the result is >255 or nd > MAX_DIGITS, pulse ovfErr once and go to DISCARD. A separator pulses numValid with numData = acc[7:0], increments numCount, and goes to SEP. Any other byte pulses charErr and goes to DISCARD.
  - DISCARD: digits and other characters are ignored with no further pulses. A separator goes to SEP.
- Latency: numValid, ovfErr and charErr assert the cycle after byteValid, which is 1 cycle after the stop-bit sample. numData holds until the next numValid.
- Leading zeros count toward nd: "0012" with MAX_DIGITS = 3 gives ovfErr.
- Consecutive separators emit nothing. An empty token emits nothing.
- rxClear: forces the parser to SEP and zeroes acc, nd and numCount. If rxClear and byteValid coincide, rxClear wins and the byte is dropped.
- Error pulses are mutually exclusive per byte. frameErr may coincide with a parser pulse from the previous byte only if its timing allows; each pulse is independent.

Decomposition:
- Shared package (info_uart_pkg):
  - ASCII constants: ASCII_0 = 8'h30, ASCII_9 = 8'h39, ASCII_SP = 8'h20, ASCII_CR = 8'h0D, ASCII_LF = 8'h0A, ASCII_STAR = 8'h2A. The same constants are used by the TX path.
  - Parser state enum.
  - Byte-FSM state enum.
- One sub-module: uart_rx_byte. It contains the synchroniser and bit FSM, with outputs rxByte[7:0], byteValid, frameErr and rxBusy. The top holds the parser.

Test Plan:
- Send "12 " at 115200 -> exactly one numValid with numData = 12, numCount = 1, no error pulses.
- Send "255\r3\n" -> numValid 255 then numValid 3, numCount = 2.
- Send "256 7 " -> ovfErr once on '6', no numValid for 256, then numValid 7. Also send "0012 " -> ovfErr.
- Send "1a2 9 " -> charErr once on 'a', no further pulses until the separator, then numValid 9.
- Byte 0x31 with stop bit forced 0 -> frameErr pulse, parser stays in SEP. Then " 5 " -> numValid 5. A 200-cycle low glitch -> no byteValid, no frameErr.
- Assert uartRxRst mid-data-bit, then send "4 " -> no pulse from the aborted frame, numValid 4, numCount = 1. Assert rxClear after "8" and before " " -> no numValid for 8.

Source files
------------

// File: rtl/info_uart_pkg.sv
// info_uart_pkg: ASCII constants, FSM state types and character classifiers shared by the info UART paths.
package info_uart_pkg;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_STAR = 8'h2A;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
  typedef enum logic [1:0] {P_SEP, P_NUM, P_DISC} parse_state_t;
  function automatic logic is_digit(input logic [7:0] c);
    return c >= ASCII_0 && c <= ASCII_9;
  endfunction
  function automatic logic is_sep(input logic [7:0] c);
    return c == ASCII_SP || c == ASCII_CR || c == ASCII_LF;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with 2-flop input synchroniser and mid-bit sampling.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxByte,
  output logic       byteValid,
  output logic       frameErr,
  output logic       rxBusy
);
  import info_uart_pkg::*;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  byte_state_t   r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic          w_rx;
  assign w_rx = r_sync[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_state   <= B_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      rxByte    <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
      rxBusy    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rx};
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
      r_cnt     <= r_cnt + 1'b1;
      case (r_state)
        B_IDLE: begin
          r_cnt <= '0;
          if (!w_rx) begin
            r_state <= B_START;
            rxBusy  <= 1'b1;
          end
        end
        B_START: if (r_cnt == HALF) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= w_rx ? B_IDLE : B_DATA;
          rxBusy  <= !w_rx;
        end
        B_DATA: if (r_cnt == LAST) begin
          r_cnt  <= '0;
          rxByte <= {w_rx, rxByte[7:1]};
          r_bit  <= r_bit + 1'b1;
          if (r_bit == 3'd7) r_state <= B_STOP;
        end
        default: if (r_cnt == LAST) begin
          r_state   <= B_IDLE;
          rxBusy    <= 1'b0;
          byteValid <= w_rx;
          frameErr  <= !w_rx;
        end
      endcase
    end
  end
endmodule

// File: rtl/info_uart_rx.sv
// info_uart_rx: UART receiver that parses whitespace-separated ASCII decimal tokens into 8-bit values.
module info_uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       uartRxRst,
  input  logic       uartRx,
  input  logic       rxClear,
  output logic [7:0] numData,
  output logic       numValid,
  output logic [7:0] numCount,
  output logic       ovfErr,
  output logic       charErr,
  output logic       frameErr,
  output logic       rxBusy
);
  import info_uart_pkg::*;
  localparam int NW = $clog2(MAX_DIGITS + 2);
  parse_state_t r_state;
  logic [11:0]  r_acc;
  logic [NW-1:0] r_nd;
  logic [7:0]   w_byte;
  logic         w_byte_valid;
  logic [11:0]  w_next;
  logic         w_ovf;
  uart_rx_byte #(.CLKS_PER_BIT(CLK_FREQ / BAUD)) u_byte (
    .clk(clk), .rst(uartRxRst), .rx(uartRx), .rxByte(w_byte),
    .byteValid(w_byte_valid), .frameErr(frameErr), .rxBusy(rxBusy)
  );
  // 12 bits hold 255*10+9 without wrapping, so the >255 test is exact
  assign w_next = r_acc * 12'd10 + {8'd0, w_byte[3:0]};
  assign w_ovf  = w_next > 12'd255 || int'(r_nd) >= MAX_DIGITS;
  always_ff @(posedge clk) begin
    if (uartRxRst) begin
      r_state  <= P_SEP;
      r_acc    <= '0;
      r_nd     <= '0;
      numData  <= '0;
      numValid <= 1'b0;
      numCount <= '0;
      ovfErr   <= 1'b0;
      charErr  <= 1'b0;
    end else begin
      numValid <= 1'b0;
      ovfErr   <= 1'b0;
      charErr  <= 1'b0;
      if (rxClear) begin
        r_state  <= P_SEP;
        r_acc    <= '0;
        r_nd     <= '0;
        numCount <= '0;
      end else if (w_byte_valid) begin
        case (r_state)
          P_SEP: if (is_digit(w_byte)) begin
            r_acc   <= {8'd0, w_byte[3:0]};
            r_nd    <= NW'(1);
            r_state <= P_NUM;
          end else if (!is_sep(w_byte)) begin
            charErr <= 1'b1;
            r_state <= P_DISC;
          end
          P_NUM: if (is_digit(w_byte)) begin
            r_acc   <= w_next;
            r_nd    <= r_nd + 1'b1;
            ovfErr  <= w_ovf;
            r_state <= w_ovf ? P_DISC : P_NUM;
          end else if (is_sep(w_byte)) begin
            numValid <= 1'b1;
            numData  <= r_acc[7:0];
            numCount <= numCount + 1'b1;
            r_state  <= P_SEP;
          end else begin
            charErr <= 1'b1;
            r_state <= P_DISC;
          end
          default: if (is_sep(w_byte)) r_state <= P_SEP;
        endcase
      end
    end
  end
endmodule
